// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and defaults for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int unsigned IF_XLEN       = 32;
    localparam int unsigned IF_FIFO_DEPTH = 2;

    // One fetched instruction together with the address it was fetched from.
    // The fetch unit packs its buffer entries in this same {pc, instr} order.
    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } fetch_entry_t;

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fifo.sv
`default_nettype none
// ============================================================================
// Module      : if_fifo
// Description : Small synchronous FIFO with push/pop/clear and occupancy
//               count. A pop and a push may happen in the same cycle even
//               when full. The head is read straight from the registered
//               storage, so data_o never depends combinationally on data_i.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Qualify the handshakes and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != FULL_COUNT) || do_pop);
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer/count state; clear empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; reset to zero so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage behind the PC register. Issues PC to instruction
//               memory under a credit limit (in-flight + buffered never
//               exceeds FIFO_DEPTH), pairs in-order responses with their PCs,
//               buffers them for decode and drops stale responses after a
//               redirect using a discard counter.
//               Optional build macro IF_MISALIGN_CHECK_EN: blocks fetches
//               from a PC with PC[1:0] != 0 and raises fetch_misalign_o once
//               the pipeline has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned XLEN       = IF_XLEN,
    parameter int unsigned FIFO_DEPTH = IF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            pc_stall_o,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misalign_o
`endif
);

    localparam int unsigned CW        = cnt_width(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     discard_q,     discard_d;
    logic [CW-1:0]     buf_count;
    logic [CW-1:0]     pcq_count;
    logic [CW:0]       occupancy;
    logic              pc_ok;
    logic              req_valid;
    logic              accept;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              buf_pop;
    logic [XLEN-1:0]   rsp_pc;
    logic [2*XLEN-1:0] buf_din;
    logic [2*XLEN-1:0] buf_dout;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    assign pc_ok = (pc_i[1:0] == 2'b00);
`else
    assign pc_ok = 1'b1;
`endif

    // Credit check: every accepted request is guaranteed a buffer slot on return.
    // Gating with rst_n keeps the request low and the stall high while in reset.
    assign occupancy        = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign req_valid        = rst_n && !flush_i && pc_ok && (occupancy < DEPTH_EXT);
    assign accept           = req_valid && imem_req_ready_i;
    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_i;
    assign pc_stall_o       = !accept;

    // A response with nothing outstanding is a protocol error and is ignored.
    // Responses are dropped while stale ones remain, or when they collide with a redirect.
    assign rsp_fire = imem_rsp_valid_i && (outstanding_q != '0);
    assign rsp_keep = rsp_fire && (discard_q == '0) && !flush_i;
    assign buf_din  = {rsp_pc, imem_rsp_data_i};
    assign buf_pop  = instr_valid_o && instr_ready_i;

    assign instr_valid_o = (buf_count != '0);
    assign instr_pc_o    = buf_dout[2*XLEN-1:XLEN];
    assign instr_o       = buf_dout[XLEN-1:0];

    // PCs of accepted requests, popped in order as responses return. It is
    // never cleared: after a redirect it keeps tracking the stale requests.
    if_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (1'b0),
        .push_i  (accept),
        .data_i  (pc_i),
        .pop_i   (rsp_fire),
        .data_o  (rsp_pc),
        .count_o (pcq_count)
    );

    // Instruction buffer towards decode, emptied on redirect.
    if_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush_i),
        .push_i  (rsp_keep),
        .data_i  (buf_din),
        .pop_i   (buf_pop),
        .data_o  (buf_dout),
        .count_o (buf_count)
    );

    // Outstanding and discard bookkeeping; a redirect marks everything still
    // in flight after this cycle's response as stale (no request is issued then).
    always_comb begin
        outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_fire);
        discard_d     = discard_q;
        if (flush_i) begin
            discard_d = outstanding_q - CW'(rsp_fire);
        end else if (rsp_fire && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    // Misalign flag rises only once nothing older is in flight or buffered.
    always_comb begin
        misalign_d = misalign_q;
        if (flush_i) begin
            misalign_d = 1'b0;
        end else if (!pc_ok && (outstanding_q == '0) && (buf_count == '0)) begin
            misalign_d = 1'b1;
        end
    end

    // Misalign flag register, held until redirect or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_misalign_o = misalign_q;
`endif

`ifndef SYNTHESIS
    a_outstanding_bound : assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= CW'(FIFO_DEPTH));
    a_rsp_with_outstanding : assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid_i |-> (outstanding_q != '0));
    a_pc_queue_tracks : assert property (@(posedge clk) disable iff (!rst_n)
        pcq_count == outstanding_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed bench for instr_fetch_unit with a variable-latency
//               memory model and an epoch-tagged scoreboard of expected
//               decode-side entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import if_pkg::*;

    localparam int unsigned XLEN  = IF_XLEN;
    localparam int unsigned DEPTH = IF_FIFO_DEPTH;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] pc;
    logic            flush;
    logic            pc_stall;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
`ifdef IF_MISALIGN_CHECK_EN
    logic            fetch_misalign;
    logic            mis_model;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
        logic [31:0] epoch;
    } mem_req_t;

    mem_req_t     mem_q[$];
    fetch_entry_t exp_q[$];

    int          checks;
    int          errors;
    int          cyc;
    int          epoch;
    int          lat;
    int          accepts;
    logic [31:0] pc_model;
    logic [31:0] flush_target;
    logic        popped;
    logic [31:0] popped_pc;
    logic        seen;
    logic [31:0] first_pc;

    instr_fetch_unit #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc_i             (pc),
        .flush_i          (flush),
        .pc_stall_o       (pc_stall),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .instr_valid_o    (instr_valid),
        .instr_ready_i    (instr_ready),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .fetch_misalign_o (fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, update the memory model
    // and scoreboard, then drive the next cycle's inputs just after the rising edge.
    task automatic tick();
        mem_req_t     h;
        fetch_entry_t e;
        logic         exp_req;
        logic         acc;
        @(negedge clk);
        popped = 1'b0;
        chk("instr_valid", instr_valid, exp_q.size() != 0);
        exp_req = !flush && ((mem_q.size() + exp_q.size()) < DEPTH);
`ifdef IF_MISALIGN_CHECK_EN
        exp_req = exp_req && (pc[1:0] == 2'b00);
        chk("fetch_misalign", fetch_misalign, mis_model);
        if (flush) mis_model = 1'b0;
        else if ((pc[1:0] != 2'b00) && (mem_q.size() == 0) && (exp_q.size() == 0)) mis_model = 1'b1;
`endif
        chk("req_valid", req_valid, exp_req);
        acc = req_valid && req_ready;
        chk("pc_stall", pc_stall, !acc);
        if (req_valid) chk("req_addr", req_addr, pc_model);
        if (instr_valid && instr_ready && (exp_q.size() != 0)) begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc, e.pc);
            chk("instr", instr, e.instr);
            popped    = 1'b1;
            popped_pc = instr_pc;
            if (!seen) begin
                seen     = 1'b1;
                first_pc = instr_pc;
            end
        end
        if (flush) begin
            epoch++;
            exp_q.delete();
        end
        if (rsp_valid && (mem_q.size() != 0)) begin
            h = mem_q.pop_front();
            if (h.epoch == epoch) exp_q.push_back('{pc: h.addr, instr: instr_of(h.addr)});
        end
        if (acc) begin
            accepts++;
            mem_q.push_back('{addr: req_addr, due: cyc + lat, epoch: epoch});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (flush) pc_model = flush_target;
        else if (acc) pc_model = pc_model + 32'd4;
        flush     = 1'b0;
        pc        = pc_model;
        rsp_valid = (mem_q.size() != 0) && (mem_q[0].due == cyc);
        rsp_data  = rsp_valid ? instr_of(mem_q[0].addr) : '0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush        = 1'b1;
        flush_target = target;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; epoch = 0; lat = 1; accepts = 0;
        pc_model = '0; flush_target = '0; popped = 1'b0; popped_pc = '0;
        seen = 1'b1; first_pc = '0;
        rst_n = 1'b0; pc = '0; flush = 1'b0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_data = '0; instr_ready = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
        mis_model = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, '0);
        chk("rst_instr_pc", instr_pc, '0);
        chk("rst_pc_stall", pc_stall, 1'b1);
`ifdef IF_MISALIGN_CHECK_EN
        chk("rst_misalign", fetch_misalign, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: streaming from PC 0 with a 1-cycle memory; first entry after 2 cycles
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 2) begin
                chk("t1_first_pop", popped, 1'b1);
                chk("t1_first_pc", popped_pc, 32'h0);
            end
        end

        // 2: decode stalled for 10 cycles -> exactly DEPTH accepts, then resume in order
        do_flush(32'h40);
        instr_ready = 1'b0;
        accepts = 0;
        repeat (10) tick();
        chk("t2_accepts", accepts, DEPTH);
        chk("t2_stall_held", pc_stall, 1'b1);
        instr_ready = 1'b1;
        seen = 1'b0;
        repeat (8) tick();
        chk("t2_first_pc", first_pc, 32'h40);

        // 3: 3-cycle memory, two requests in flight, redirect drops both
        lat = 3;
        do_flush(32'h10);
        accepts = 0;
        for (int i = 0; i < 10 && accepts < 2; i++) tick();
        chk("t3_inflight", accepts, 2);
        do_flush(32'h100);
        chk("t3_valid_after_flush", instr_valid, 1'b0);
        seen = 1'b0;
        repeat (15) tick();
        chk("t3_first_pc", first_pc, 32'h100);

        // 4: redirect in the same cycle as a response
        lat = 1;
        do_flush(32'h200);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        chk("t4_rsp_pending", rsp_valid, 1'b1);
        do_flush(32'h300);
        chk("t4_valid_after_flush", instr_valid, 1'b0);
        seen = 1'b0;
        repeat (8) tick();
        chk("t4_first_pc", first_pc, 32'h300);

        // 5: random memory back-pressure, 2-cycle latency
        lat = 2;
        do_flush(32'h400);
        for (int i = 0; i < 40; i++) begin
            req_ready   = 1'($urandom_range(0, 1));
            instr_ready = (i % 7) != 3;
            tick();
        end
        req_ready   = 1'b1;
        instr_ready = 1'b1;
        repeat (10) tick();

`ifdef IF_MISALIGN_CHECK_EN
        // 6: misaligned PC blocks fetch, flag after drain, redirect clears it
        lat = 1;
        do_flush(32'h102);
        accepts = 0;
        repeat (6) tick();
        chk("t6_no_request", accepts, 0);
        chk("t6_misalign_set", fetch_misalign, 1'b1);
        do_flush(32'h200);
        chk("t6_misalign_clear", fetch_misalign, 1'b0);
        repeat (4) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
